// File: rtl/count_pkg.sv
// Shared constants for the count_udn up/down counter: overflow modes and
// legal parameter ranges.
package count_pkg;

    localparam int COUNT_WRAP = 0;
    localparam int COUNT_SAT  = 1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    localparam int PRESC_DIV_MIN = 2;
    localparam int PRESC_DIV_MAX = 256;

endpackage

// File: rtl/count_presc.sv
// Enable prescaler for count_udn: tick pulses on every DIV-th enabled edge.
// Only compiled when COUNT_PRESCALE_EN is defined.
`ifdef COUNT_PRESCALE_EN
module count_presc
    import count_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic EN,
    output logic tick
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    assign tick = EN && (phase == LAST);

    // Phase only advances on enabled edges, so gaps in EN preserve it.
    always_ff @(posedge clk) begin
        if (res || clr) begin
            phase <= '0;
        end else if (EN) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

endmodule
`endif

// File: rtl/count_udn.sv
// Loadable up/down counter with wrap or saturate limits and a sticky OVF flag.
// Optional enable prescaler when COUNT_PRESCALE_EN is defined.
module count_udn
    import count_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SAT       = COUNT_WRAP,
    parameter int PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] CNT_In,
    input  logic [WIDTH-1:0] CNT_Max,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             OVF
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        PRESC_DIV < PRESC_DIV_MIN || PRESC_DIV > PRESC_DIV_MAX ||
        (SAT != COUNT_WRAP && SAT != COUNT_SAT)) begin : g_bad_param
        $error("count_udn: parameter out of legal range");
    end

    logic tick;

`ifdef COUNT_PRESCALE_EN
    count_presc #(
        .DIV (PRESC_DIV)
    ) u_presc (
        .clk  (clk),
        .res  (res),
        .clr  (load),
        .EN   (EN),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    logic             step;
    logic             at_limit;
    logic [WIDTH-1:0] cnt_next;
    logic             ovf_next;

    assign step     = EN && tick;
    // >= rather than == so a loaded value above CNT_Max still hits the limit.
    assign at_limit = up ? (CNT >= CNT_Max) : (CNT == '0);
    assign TC       = step && at_limit;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cnt_next = CNT;
        ovf_next = OVF;

        if (clr_ovf) begin
            ovf_next = 1'b0;
        end

        if (load) begin
            cnt_next = CNT_In;
        end else if (step) begin
            if (at_limit) begin
                ovf_next = 1'b1;
                if (SAT == COUNT_WRAP) begin
                    cnt_next = up ? '0 : CNT_Max;
                end
            end else begin
                cnt_next = up ? CNT + WIDTH'(1) : CNT - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (res) begin
            CNT <= '0;
            OVF <= 1'b0;
        end else begin
            CNT <= cnt_next;
            OVF <= ovf_next;
        end
    end

endmodule

// File: tb/tb_count_udn.sv
// Self-checking bench for count_udn: wrap and saturate instances side by side,
// reference model feeding a scoreboard queue, plus directed literal checks.
module tb_count_udn;

    localparam int W    = 8;
    localparam int PDIV = 4;

    logic         clk = 1'b0;
    logic         res;
    logic         en;
    logic         load;
    logic         up;
    logic [W-1:0] cnt_in;
    logic [W-1:0] cnt_max;
    logic         clr_ovf;

    logic [W-1:0] cnt_w, cnt_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    count_udn #(.WIDTH(W), .SAT(0), .PRESC_DIV(PDIV)) dut_w (
        .clk(clk), .res(res), .EN(en), .load(load), .up(up),
        .CNT_In(cnt_in), .CNT_Max(cnt_max), .clr_ovf(clr_ovf),
        .CNT(cnt_w), .TC(tc_w), .OVF(ovf_w)
    );

    count_udn #(.WIDTH(W), .SAT(1), .PRESC_DIV(PDIV)) dut_s (
        .clk(clk), .res(res), .EN(en), .load(load), .up(up),
        .CNT_In(cnt_in), .CNT_Max(cnt_max), .clr_ovf(clr_ovf),
        .CNT(cnt_s), .TC(tc_s), .OVF(ovf_s)
    );

    typedef struct {
        logic [W-1:0] cnt_w;
        logic         ovf_w;
        logic [W-1:0] cnt_s;
        logic         ovf_s;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_cnt_w = '0, m_cnt_s = '0;
    logic         m_ovf_w = 1'b0, m_ovf_s = 1'b0;
    int           m_presc = 0;
    bit           m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {ovf, cnt} after one edge for the given mode.
    function automatic logic [W:0] model_next(input bit sat, input logic [W-1:0] c,
                                              input logic o, input bit tk);
        logic [W-1:0] nc;
        logic         no;
        nc = c;
        no = o;
        if (clr_ovf) no = 1'b0;
        if (res) begin
            nc = '0;
            no = 1'b0;
        end else if (load) begin
            nc = cnt_in;
        end else if (en && tk) begin
            if (up) begin
                if (c >= cnt_max) begin
                    no = 1'b1;
                    nc = sat ? c : '0;
                end else begin
                    nc = c + 8'd1;
                end
            end else begin
                if (c == '0) begin
                    no = 1'b1;
                    nc = sat ? c : cnt_max;
                end else begin
                    nc = c - 8'd1;
                end
            end
        end
        return {no, nc};
    endfunction

    function automatic bit model_tc(input logic [W-1:0] c, input bit tk);
        return en && tk && (up ? (c >= cnt_max) : (c == '0));
    endfunction

    // One clock edge: check TC, predict, push, clock, pop, compare.
    task automatic step();
        exp_t       e;
        bit         tk;
        logic [W:0] r;
        #1;
`ifdef COUNT_PRESCALE_EN
        tk = en && (m_presc == PDIV - 1);
`else
        tk = 1'b1;
`endif
        if (m_valid) begin
            check("tc_wrap", tc_w, model_tc(m_cnt_w, tk));
            check("tc_sat", tc_s, model_tc(m_cnt_s, tk));
        end
        r = model_next(1'b0, m_cnt_w, m_ovf_w, tk);
        e.cnt_w = r[W-1:0];
        e.ovf_w = r[W];
        r = model_next(1'b1, m_cnt_s, m_ovf_s, tk);
        e.cnt_s = r[W-1:0];
        e.ovf_s = r[W];
        sb.push_back(e);
        m_cnt_w = e.cnt_w;
        m_ovf_w = e.ovf_w;
        m_cnt_s = e.cnt_s;
        m_ovf_s = e.ovf_s;
        if (res || load) m_presc = 0;
        else if (en) m_presc = (m_presc == PDIV - 1) ? 0 : m_presc + 1;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("cnt_wrap", cnt_w, e.cnt_w);
        check("ovf_wrap", ovf_w, e.ovf_w);
        check("cnt_sat", cnt_s, e.cnt_s);
        check("ovf_sat", ovf_s, e.ovf_s);
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic u,
                         input logic [W-1:0] ci, input logic [W-1:0] cm, input logic co);
        res     = r;
        en      = e;
        load    = l;
        up      = u;
        cnt_in  = ci;
        cnt_max = cm;
        clr_ovf = co;
    endtask

    initial begin
        logic [W-1:0] seq_up [6];
        logic [W-1:0] seq_dn [4];
        seq_up = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        seq_dn = '{8'd1, 8'd0, 8'd0, 8'd0};

        // Reset overrides load and EN.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h05, 1'b0);
        step();
        step();
        check("reset_cnt", cnt_w, 8'h00);
        check("reset_ovf", ovf_w, 1'b0);

`ifdef COUNT_PRESCALE_EN
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 12; i++) step();
        check("presc_12_edges", cnt_w, 8'd3);
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        en = 1'b1;
        step();
        check("presc_hold_phase", cnt_w, 8'd3);
        step();
        check("presc_resume", cnt_w, 8'd4);
`else
        // Wrap up from 0 with CNT_Max=5.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h05, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("wrap_tc_at_max", tc_w, 1'b1);
            else if (i == 4) check("wrap_ovf_before", ovf_w, 1'b0);
            step();
            check("wrap_seq", cnt_w, seq_up[i]);
        end
        check("wrap_ovf_set", ovf_w, 1'b1);

        // Saturating down from a loaded 2, OVF cleared during the load.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h05, 1'b1);
        step();
        load    = 1'b0;
        clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sat_seq", cnt_s, seq_dn[i]);
            if (i == 0) check("sat_ovf_clear", ovf_s, 1'b0);
        end
        check("sat_ovf_set", ovf_s, 1'b1);
        clr_ovf = 1'b1;
        step();
        check("sat_set_beats_clr", ovf_s, 1'b1);

        // Load above the limit, then an up step takes the limit branch.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h10, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h10, 1'b0);
        step();
        check("over_limit_wrap", cnt_w, 8'h00);
        check("over_limit_sat", cnt_s, 8'h20);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h10, 1'b0);
        step();
        check("load_beats_step", cnt_w, 8'h33);

        // Direction flip at 3.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h10, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h10, 1'b0);
        step();
        check("flip_at_3", cnt_w, 8'h03);
        up = 1'b0;
        step();
        check("flip_down", cnt_w, 8'h02);
        check("flip_no_ovf", ovf_w, 1'b0);

        // Reset mid-count, then resume from 0.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 8'h10, 1'b0);
        step();
        load = 1'b0;
        step();
        check("midrun_pre", cnt_w, 8'h08);
        res = 1'b1;
        step();
        check("midrun_reset", cnt_w, 8'h00);
        res = 1'b0;
        step();
        check("midrun_resume", cnt_w, 8'h01);
`endif

        // Random traffic, checked against the model only.
        for (int i = 0; i < 400; i++) begin
            res     = ($urandom_range(0, 99) < 3);
            en      = ($urandom_range(0, 99) < 75);
            load    = ($urandom_range(0, 99) < 10);
            up      = $urandom_range(0, 1) != 0;
            cnt_in  = W'($urandom_range(0, 15));
            cnt_max = ($urandom_range(0, 9) == 0) ? 8'hFF : W'($urandom_range(0, 9));
            clr_ovf = ($urandom_range(0, 99) < 20);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
